// File: rtl/cplx_dot_acc.sv
// cplx_dot_acc: streaming complex inner-product engine.
// Accepts N complex sample pairs (z[k], j[k]) per frame over valid/ready
// and returns one full-precision complex sum of z[k]*j[k].
// Pipeline: stage 1 multiply, stage 2 combine, stage 3 accumulate.
// Build option: define CPLX_DOT_CONJ_EN to accumulate z[k]*conj(j[k]) instead.
// Latency, widths and handshake are the same in both builds.
module cplx_dot_acc #(
    parameter  int DW   = 32,
    parameter  int N    = 64,
    localparam int ACCW = 2*DW + 1 + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_z_re,
    input  logic [DW-1:0]   in_z_im,
    input  logic [DW-1:0]   in_j_re,
    input  logic [DW-1:0]   in_j_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_re,
    output logic [ACCW-1:0] out_im,
    output logic            busy
);

    localparam int PW   = 2*DW;
    localparam int SW   = 2*DW + 1;
    localparam int CNTW = $clog2(N);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(N-1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]             state;
    logic [CNTW-1:0]        count;
    logic                   drain_cnt;
    logic                   accept;
    logic                   handshake;
    logic                   out_valid_r;

    logic                   s1_valid;
    logic signed [PW-1:0]   p_rr;
    logic signed [PW-1:0]   p_ii;
    logic signed [PW-1:0]   p_ri;
    logic signed [PW-1:0]   p_ir;

    logic                   s2_valid;
    logic [SW-1:0]          s2_re;
    logic [SW-1:0]          s2_im;

    logic [ACCW-1:0]        acc_re;
    logic [ACCW-1:0]        acc_im;

    assign in_ready  = !rst && (state == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign handshake = out_valid_r && out_ready;
    assign out_re    = acc_re;
    assign out_im    = acc_im;
    assign busy      = (state != ST_ACCUM) || (count != '0);

    // Frame control: count beats, flush the two trailing stages, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            count     <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (count == LAST_BEAT) begin
                            count     <= '0;
                            drain_cnt <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            count <= count + CNTW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (handshake) begin
                        state <= ST_ACCUM;
                        count <= '0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // Result valid is registered one cycle after the final accumulate so the sums are settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (handshake) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state == ST_DONE);
        end
    end

    // Stage 1: capture the four cross products of an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                p_rr <= PW'($signed(in_z_re)) * PW'($signed(in_j_re));
                p_ii <= PW'($signed(in_z_im)) * PW'($signed(in_j_im));
                p_ri <= PW'($signed(in_z_re)) * PW'($signed(in_j_im));
                p_ir <= PW'($signed(in_z_im)) * PW'($signed(in_j_re));
            end
        end
    end

    // Stage 2: combine products into one complex term, one bit wider to absorb the add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
`ifdef CPLX_DOT_CONJ_EN
                s2_re <= {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
                s2_im <= {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
`else
                s2_re <= {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
                s2_im <= {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
`endif
            end
        end
    end

    // Stage 3: accumulate valid terms only; cleared when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (handshake) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (s2_valid) begin
            acc_re <= acc_re + {{(ACCW-SW){s2_re[SW-1]}}, s2_re};
            acc_im <= acc_im + {{(ACCW-SW){s2_im[SW-1]}}, s2_im};
        end
    end

endmodule

// File: tb/tb_cplx_dot_acc.sv
// Testbench for cplx_dot_acc with DW=8, N=4 (ACCW=19).
// Expected sums come from a plain integer model of the complex dot product.
module tb_cplx_dot_acc;

    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int ACCW = 2*DW + 1 + $clog2(N);

`ifdef CPLX_DOT_CONJ_EN
    localparam int T1_RE = 44;
    localparam int T1_IM = 8;
    localparam int T3_RE = 131072;
    localparam int T3_IM = 0;
`else
    localparam int T1_RE = -20;
    localparam int T1_IM = 40;
    localparam int T3_RE = 0;
    localparam int T3_IM = 131072;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_z_re;
    logic [DW-1:0]   in_z_im;
    logic [DW-1:0]   in_j_re;
    logic [DW-1:0]   in_j_im;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_re;
    logic [ACCW-1:0] out_im;
    logic            busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int fz_re[8];
    int fz_im[8];
    int fj_re[8];
    int fj_im[8];

    cplx_dot_acc #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z_re(in_z_re), .in_z_im(in_z_im),
        .in_j_re(in_j_re), .in_j_im(in_j_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Reference: complex sum over one frame using plain integer arithmetic.
    function automatic void model(input int base, output int er, output int ei);
        er = 0;
        ei = 0;
        for (int k = 0; k < N; k++) begin
`ifdef CPLX_DOT_CONJ_EN
            er += fz_re[base+k]*fj_re[base+k] + fz_im[base+k]*fj_im[base+k];
            ei += fz_im[base+k]*fj_re[base+k] - fz_re[base+k]*fj_im[base+k];
`else
            er += fz_re[base+k]*fj_re[base+k] - fz_im[base+k]*fj_im[base+k];
            ei += fz_re[base+k]*fj_im[base+k] + fz_im[base+k]*fj_re[base+k];
`endif
        end
    endfunction

    task automatic fill_const(input int base, input int zr, input int zi, input int jr, input int ji);
        for (int k = 0; k < N; k++) begin
            fz_re[base+k] = zr; fz_im[base+k] = zi;
            fj_re[base+k] = jr; fj_im[base+k] = ji;
        end
    endtask

    task automatic fill_rand(input int base);
        for (int k = 0; k < N; k++) begin
            fz_re[base+k] = rnd8(); fz_im[base+k] = rnd8();
            fj_re[base+k] = rnd8(); fj_im[base+k] = rnd8();
        end
    endtask

    task automatic put_beat(input int i);
        in_z_re = DW'(fz_re[i]); in_z_im = DW'(fz_im[i]);
        in_j_re = DW'(fj_re[i]); in_j_im = DW'(fj_im[i]);
    endtask

    task automatic put_junk();
        in_z_re = DW'($urandom); in_z_im = DW'($urandom);
        in_j_re = DW'($urandom); in_j_im = DW'($urandom);
    endtask

    // Drives nbeats beats from the stored arrays; returns the edge that accepted the last one.
    task automatic drive_frame(input int base, input int nbeats, input bit bubbles,
                               output int last_edge, output bit timeout);
        int k = 0;
        int guard = 0;
        bit tog = 1'b1;
        timeout = 1'b0;
        last_edge = -1;
        while (k < nbeats) begin
            @(negedge clk);
            guard = guard + 1;
            if (guard > 200) begin
                timeout = 1'b1;
                break;
            end
            in_valid = bubbles ? tog : 1'b1;
            tog = !tog;
            if (in_valid) put_beat(base + k);
            else put_junk();
            if (in_valid && in_ready) begin
                k = k + 1;
                last_edge = cyc + 1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        put_junk();
    endtask

    // Waits at negedges until out_valid; returns the edge count at which it was first seen.
    task automatic wait_valid(output int rise_edge, output bit timeout);
        int guard = 0;
        timeout = 1'b0;
        rise_edge = -1;
        while (!out_valid) begin
            @(negedge clk);
            guard = guard + 1;
            if (guard > 50) begin
                timeout = 1'b1;
                break;
            end
        end
        if (!timeout) rise_edge = cyc;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 5;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        if (out_re !== '0) begin n_fail++; $display("[TB] FAIL reset_out_re: got %0d, expected 0", $signed(out_re)); end
        if (out_im !== '0) begin n_fail++; $display("[TB] FAIL reset_out_im: got %0d, expected 0", $signed(out_im)); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
    endtask

    // Runs one frame and checks result, latency, busy and post-handshake state.
    task automatic test_frame(input string name, input int base, input bit bubbles,
                              input int exp_re, input int exp_im, input int hold);
        int last_edge, rise_edge;
        bit to1, to2;
        drive_frame(base, N, bubbles, last_edge, to1);
        wait_valid(rise_edge, to2);
        n_checks += 6;
        if (to1 || to2) begin n_fail++; $display("[TB] FAIL %s_timeout: got drive=%b wait=%b, expected 0 0", name, to1, to2); end
        if (rise_edge - last_edge !== 3) begin n_fail++; $display("[TB] FAIL %s_latency: got %0d, expected 3", name, rise_edge - last_edge); end
        if (out_re !== ACCW'(exp_re)) begin n_fail++; $display("[TB] FAIL %s_re: got %0d, expected %0d", name, $signed(out_re), exp_re); end
        if (out_im !== ACCW'(exp_im)) begin n_fail++; $display("[TB] FAIL %s_im: got %0d, expected %0d", name, $signed(out_im), exp_im); end
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_busy_done: got %b, expected 1", name, busy); end
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_ready_done: got %b, expected 0", name, in_ready); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_hold_valid: got %b, expected 1", name, out_valid); end
            if (out_re !== ACCW'(exp_re)) begin n_fail++; $display("[TB] FAIL %s_hold_re: got %0d, expected %0d", name, $signed(out_re), exp_re); end
            if (out_im !== ACCW'(exp_im)) begin n_fail++; $display("[TB] FAIL %s_hold_im: got %0d, expected %0d", name, $signed(out_im), exp_im); end
            if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_hold_ready: got %b, expected 0", name, in_ready); end
        end
        do_handshake();
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_valid_after: got %b, expected 0", name, out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_busy_after: got %b, expected 0", name, busy); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_ready_after: got %b, expected 1", name, in_ready); end
    endtask

    task automatic test_basic();
        fill_const(0, 1, 2, 3, 4);
        test_frame("basic", 0, 1'b0, T1_RE, T1_IM, 0);
    endtask

    task automatic test_bubbles();
        int er, ei;
        fill_const(0, 1, 2, 3, 4);
        test_frame("bubbles", 0, 1'b1, T1_RE, T1_IM, 0);
        fill_rand(0);
        model(0, er, ei);
        test_frame("bubbles_rand", 0, 1'b1, er, ei, 0);
    endtask

    task automatic test_extreme();
        fill_const(0, -128, -128, -128, -128);
        test_frame("extreme", 0, 1'b0, T3_RE, T3_IM, 0);
    endtask

    task automatic test_backpressure();
        int er, ei;
        fill_rand(0);
        model(0, er, ei);
        test_frame("backpressure", 0, 1'b0, er, ei, 5);
    endtask

    task automatic test_reset_midframe();
        int last_edge;
        bit to;
        fill_rand(0);
        drive_frame(0, 2, 1'b0, last_edge, to);
        n_checks += 2;
        if (to) begin n_fail++; $display("[TB] FAIL midrst_timeout: got 1, expected 0"); end
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b, expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b, expected 0", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
        if (out_re !== '0) begin n_fail++; $display("[TB] FAIL midrst_out_re: got %0d, expected 0", $signed(out_re)); end
        @(negedge clk);
        rst = 1'b0;
        fill_const(0, 1, 2, 3, 4);
        test_frame("midrst_frameB", 0, 1'b0, T1_RE, T1_IM, 0);
    endtask

    task automatic test_back_to_back();
        int er[2], ei[2];
        int acc_edge[8];
        int hs_edge[2];
        int rise[2];
        int k = 0;
        int r = 0;
        int guard = 0;
        fill_rand(0);
        fill_rand(4);
        model(0, er[0], ei[0]);
        model(4, er[1], ei[1]);
        out_ready = 1'b1;
        while (r < 2 && guard < 100) begin
            @(negedge clk);
            guard = guard + 1;
            in_valid = (k < 8);
            if (k < 8) put_beat(k);
            else put_junk();
            if (out_valid) begin
                rise[r] = cyc;
                hs_edge[r] = cyc + 1;
                n_checks += 2;
                if (out_re !== ACCW'(er[r])) begin n_fail++; $display("[TB] FAIL b2b%0d_re: got %0d, expected %0d", r, $signed(out_re), er[r]); end
                if (out_im !== ACCW'(ei[r])) begin n_fail++; $display("[TB] FAIL b2b%0d_im: got %0d, expected %0d", r, $signed(out_im), ei[r]); end
                r = r + 1;
            end
            if (in_valid && in_ready) begin
                acc_edge[k] = cyc + 1;
                k = k + 1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (r != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_timeout: got %0d results, expected 2", r);
        end else begin
            n_checks += 3;
            if (acc_edge[4] !== hs_edge[0] + 1) begin n_fail++; $display("[TB] FAIL b2b_restart: got edge %0d, expected %0d", acc_edge[4], hs_edge[0] + 1); end
            if (rise[0] - acc_edge[3] !== 3) begin n_fail++; $display("[TB] FAIL b2b0_latency: got %0d, expected 3", rise[0] - acc_edge[3]); end
            if (rise[1] - acc_edge[7] !== 3) begin n_fail++; $display("[TB] FAIL b2b1_latency: got %0d, expected 3", rise[1] - acc_edge[7]); end
        end
    endtask

    task automatic test_random();
        int er, ei;
        for (int f = 0; f < 6; f++) begin
            fill_rand(0);
            model(0, er, ei);
            test_frame("random", 0, 1'($urandom_range(1)), er, ei, int'($urandom_range(3)));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_z_re = '0; in_z_im = '0; in_j_re = '0; in_j_im = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_extreme();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
